// File: rtl/hardcore_pkg.sv
// Shared constants and state encoding for the cache-line assembly path.
package hardcore_pkg;

    localparam int LINE_W           = 512;
    localparam int WORDS_PER_LINE   = 8;
    localparam int LINE_OFFSET_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } asm_state_t;

endpackage

// File: rtl/line_fifo.sv
// Small FIFO holding completed {address, line} entries.
// A push into a full FIFO is honoured when a pop happens on the same edge.
// The head reads as zero while the FIFO is empty.
module line_fifo #(
    parameter int WIDTH = 576,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/line_assembler.sv
// Collects eight beats into one cache line tagged with its aligned address.
// Bursts of the wrong length are dropped and counted; good lines go to a FIFO.
module line_assembler #(
    parameter int DATA_W = 64,
    parameter int LINE_W = hardcore_pkg::LINE_W,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat_valid,
    output logic              beat_ready,
    input  logic [DATA_W-1:0] beat_data,
    input  logic [ADDR_W-1:0] beat_addr,
    input  logic              beat_last,
    output logic              line_valid,
    input  logic              line_ready,
    output logic [LINE_W-1:0] linha_cache,
    output logic [ADDR_W-1:0] endereco,
    output logic [7:0]        err_count
);

    import hardcore_pkg::*;

    localparam int CNT_W     = $clog2(WORDS_PER_LINE);
    localparam int LAST_WORD = WORDS_PER_LINE - 1;
    localparam int ENTRY_W   = ADDR_W + LINE_W;
    localparam logic [ADDR_W-1:0] OFFSET_MASK =
        ADDR_W'((64'd1 << LINE_OFFSET_BITS) - 64'd1);

    asm_state_t                 state;
    logic [CNT_W-1:0]           count;
    logic [7:0]                 err_q;
    logic [ADDR_W-1:0]          addr_q;
    // Word 7 is never stored: it goes straight from beat_data into the FIFO.
    logic [LINE_W-DATA_W-1:0]   line_q;

    logic                       at_last;
    logic                       accept;
    logic                       push;
    logic                       pop;
    logic                       drop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ENTRY_W-1:0]         push_data;
    logic [ENTRY_W-1:0]         head;

    assign at_last    = (state == FILL) && (count == CNT_W'(LAST_WORD));
    assign line_valid = !fifo_empty;
    assign pop        = line_valid && line_ready;

    // Only the closing beat of a line can stall, and a same-cycle pop frees room for it.
    assign beat_ready = reset && !(at_last && fifo_full && !pop);
    assign accept     = beat_valid && beat_ready;
    assign push       = accept && at_last && beat_last;

    // A burst is bad if it ends before the eighth beat or runs past it.
    assign drop = accept && (((state == IDLE) && beat_last) ||
                             ((state == FILL) && (beat_last != at_last)));

    assign push_data   = {addr_q, beat_data, line_q};
    assign linha_cache = head[LINE_W-1:0];
    assign endereco    = head[ENTRY_W-1:LINE_W];
    assign err_count   = err_q;

    // Burst FSM, beat counter and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            err_q <= '0;
        end else begin
            if (drop && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!beat_last) begin
                            state <= FILL;
                            count <= CNT_W'(1);
                        end
                    end
                    FILL: begin
                        if (beat_last) begin
                            state <= IDLE;
                            count <= '0;
                        end else if (at_last) begin
                            state <= DRAIN;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (beat_last) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    // Line and address capture; data path registers carry no reset.
    always_ff @(posedge clk) begin
        if (accept && (state != DRAIN)) begin
            if (state == IDLE) begin
                addr_q <= beat_addr & ~OFFSET_MASK;
            end
            for (int w = 0; w < LAST_WORD; w++) begin
                if (count == CNT_W'(w)) begin
                    line_q[w*DATA_W +: DATA_W] <= beat_data;
                end
            end
        end
    end

    line_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

endmodule

// File: tb/tb_line_assembler.sv
// Directed bench for line_assembler: a per-cycle vector table plus
// hand-written sequences for back-pressure, saturation and mid-burst reset.
module tb_line_assembler;

    logic         clk = 1'b0;
    logic         reset;
    logic         beat_valid;
    logic         beat_ready;
    logic [63:0]  beat_data;
    logic [63:0]  beat_addr;
    logic         beat_last;
    logic         line_valid;
    logic         line_ready;
    logic [511:0] linha_cache;
    logic [63:0]  endereco;
    logic [7:0]   err_count;

    int checks = 0;
    int fails  = 0;
    int stalls = 0;

    typedef struct {
        bit          v;
        logic [63:0] d;
        logic [63:0] a;
        bit          l;
        bit          lr;
        bit          e_br;
        bit          e_lv;
        int          e_err;
        bit          chk;
        logic [63:0] e_addr;
        logic [63:0] e_base;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    line_assembler dut (
        .clk         (clk),
        .reset       (reset),
        .beat_valid  (beat_valid),
        .beat_ready  (beat_ready),
        .beat_data   (beat_data),
        .beat_addr   (beat_addr),
        .beat_last   (beat_last),
        .line_valid  (line_valid),
        .line_ready  (line_ready),
        .linha_cache (linha_cache),
        .endereco    (endereco),
        .err_count   (err_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*64 +: 64] = base + 64'(k);
        end
        return l;
    endfunction

    task automatic add(input bit v, input logic [63:0] d, input logic [63:0] a, input bit l,
                       input bit lr, input bit e_br, input bit e_lv, input int e_err,
                       input bit c, input logic [63:0] e_addr, input logic [63:0] e_base);
        vec_t r;
        r.v = v; r.d = d; r.a = a; r.l = l; r.lr = lr;
        r.e_br = e_br; r.e_lv = e_lv; r.e_err = e_err;
        r.chk = c; r.e_addr = e_addr; r.e_base = e_base;
        tbl.push_back(r);
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_beat(input logic [63:0] d, input logic [63:0] a, input bit l);
        int n;
        n = 0;
        beat_valid = 1'b1;
        beat_data  = d;
        beat_addr  = a;
        beat_last  = l;
        @(negedge clk);
        while (!beat_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (!beat_ready) begin
            checks++;
            fails++;
            $display("FAIL send_beat timeout: beat_ready stayed 0 for data 0x%0h", d);
        end
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
    endtask

    task automatic send_burst(input logic [63:0] base, input logic [63:0] a);
        for (int k = 0; k < 8; k++) begin
            send_beat(base + 64'(k), a, (k == 7));
        end
    endtask

    task automatic take_line(input string name, input logic [63:0] base, input logic [63:0] a);
        int n;
        n = 0;
        line_ready = 1'b1;
        @(negedge clk);
        while (!line_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".lvalid"}, 64'(line_valid), 64'd1);
        chk_line({name, ".line"}, linha_cache, mk_line(base));
        chk({name, ".addr"}, endereco, a);
        @(posedge clk);
        #1;
        line_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_addr  = '0;
        beat_last  = 1'b0;
        line_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.bready", 64'(beat_ready), 64'd0);
        chk("rst.lvalid", 64'(line_valid), 64'd0);
        chk_line("rst.line", linha_cache, '0);
        chk("rst.addr", endereco, 64'd0);
        chk("rst.err", 64'(err_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst.bready_after", 64'(beat_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single good burst; later beats carry a junk address that must be ignored
        for (int k = 0; k < 8; k++)
            add(1, 64'(k), (k == 0) ? 64'h1047 : 64'hFFFF_FFC0, (k == 7), 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0, 1, 64'h1040, 64'h0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // Short burst (4 beats), then a good burst
        for (int k = 0; k < 4; k++)
            add(1, 64'h100 + 64'(k), 64'h2000, (k == 3), 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(1, 64'h200 + 64'(k), 64'h3008, (k == 7), 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 1, 1, 64'h3000, 64'h200);
        add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        // Long burst (10 beats), then a good burst
        for (int k = 0; k < 10; k++)
            add(1, 64'h300 + 64'(k), 64'h4000, (k == 9), 1, 1, 0, (k <= 7) ? 1 : 2, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(1, 64'h400 + 64'(k), 64'h5010, (k == 7), 1, 1, 0, 2, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 2, 1, 64'h5000, 64'h400);
        add(0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0);

        foreach (tbl[i]) begin
            beat_valid = tbl[i].v;
            beat_data  = tbl[i].d;
            beat_addr  = tbl[i].a;
            beat_last  = tbl[i].l;
            line_ready = tbl[i].lr;
            @(negedge clk);
            chk($sformatf("v%0d.bready", i), 64'(beat_ready), 64'(tbl[i].e_br));
            chk($sformatf("v%0d.lvalid", i), 64'(line_valid), 64'(tbl[i].e_lv));
            chk($sformatf("v%0d.err", i), 64'(err_count), 64'(tbl[i].e_err));
            if (tbl[i].chk) begin
                chk($sformatf("v%0d.addr", i), endereco, tbl[i].e_addr);
                chk_line($sformatf("v%0d.line", i), linha_cache, mk_line(tbl[i].e_base));
            end
            @(posedge clk);
            #1;
        end
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        line_ready = 1'b0;

        // Back-pressure: two lines buffered, third line stalls on its last beat
        stalls = 0;
        send_burst(64'h500, 64'h6000);
        send_burst(64'h600, 64'h6040);
        for (int k = 0; k < 7; k++) send_beat(64'h700 + 64'(k), 64'h6080, 1'b0);
        chk("bp.stall", 64'(stalls), 64'd0);
        beat_valid = 1'b1;
        beat_data  = 64'h707;
        beat_last  = 1'b1;
        @(negedge clk);
        chk("bp.bready_full", 64'(beat_ready), 64'd0);
        chk("bp.lvalid", 64'(line_valid), 64'd1);
        chk_line("bp.headA", linha_cache, mk_line(64'h500));
        chk("bp.addrA", endereco, 64'h6000);
        @(negedge clk);
        chk("bp.bready_hold", 64'(beat_ready), 64'd0);
        chk_line("bp.headA_hold", linha_cache, mk_line(64'h500));
        line_ready = 1'b1;
        #1;
        chk("bp.bypass", 64'(beat_ready), 64'd1);
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        @(negedge clk);
        chk("bp.lvalidB", 64'(line_valid), 64'd1);
        chk_line("bp.headB", linha_cache, mk_line(64'h600));
        chk("bp.addrB", endereco, 64'h6040);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp.lvalidC", 64'(line_valid), 64'd1);
        chk_line("bp.headC", linha_cache, mk_line(64'h700));
        chk("bp.addrC", endereco, 64'h6080);
        @(posedge clk);
        #1;
        line_ready = 1'b0;
        @(negedge clk);
        chk("bp.empty", 64'(line_valid), 64'd0);
        chk("bp.err", 64'(err_count), 64'd2);
        @(posedge clk);
        #1;

        // Saturation of the drop counter with single-beat bursts
        for (int i = 0; i < 260; i++) send_beat(64'(i), 64'h0, 1'b1);
        @(negedge clk);
        chk("sat.err", 64'(err_count), 64'd255);
        chk("sat.lvalid", 64'(line_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset after four beats, then a full burst
        for (int k = 0; k < 4; k++) send_beat(64'h800 + 64'(k), 64'h7000, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst.bready", 64'(beat_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mrst.err", 64'(err_count), 64'd0);
        chk("mrst.lvalid", 64'(line_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_burst(64'h900, 64'h70C5);
        take_line("mrst", 64'h900, 64'h70C0);
        @(negedge clk);
        chk("mrst.empty", 64'(line_valid), 64'd0);
        chk("mrst.err_after", 64'(err_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/line_assembler.md
# line_assembler

Upstream feeder for `core`. It accepts a memory/trace stream of 64-bit beats, assembles each group of eight beats into one 512-bit cache line, and tags the line with its 64-byte-aligned address. Completed lines sit in a small output FIFO and are presented on `linha_cache`/`endereco` with a valid/ready handshake. Malformed bursts are dropped and counted, so the core only ever sees complete lines.

## Interface
- `DATA_W`, default 64: beat width in bits.
- `LINE_W`, default 512: cache line width; must equal `DATA_W`*8.
- `ADDR_W`, default 64: address width.
- `DEPTH`, default 2: output FIFO entries, power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `beat_valid` in 1: input beat present.
- `beat_ready` out 1: beat accepted when `beat_valid && beat_ready`.
- `beat_data` in `DATA_W`: beat payload.
- `beat_addr` in `ADDR_W`: line address; sampled on the first beat of a burst only.
- `beat_last` in 1: marks the final beat of a burst.
- `line_valid` out 1: a line is available.
- `line_ready` in 1: consumer takes the line when `line_valid && line_ready`.
- `linha_cache` out `LINE_W`: assembled line.
- `endereco` out `ADDR_W`: line address with bits [5:0] forced to 0.
- `err_count` out 8: count of dropped bursts; saturates at 255.

## Operation
- States:
  - IDLE: no partial line.
  - FILL: beat count 1..7 accepted.
  - DRAIN: discarding the rest of a bad burst.
- IDLE + accepted beat:
  - capture `beat_addr & ~0x3F` and place the beat at word 0;
  - count=1, go to FILL.
  - If `beat_last` is also high, this is a short burst: drop it, increment `err_count`, stay in IDLE.
- FILL + accepted beat k (k = count): write `beat_data` to bits [64k+63:64k] (word 0 is LSB).
  - k<7 with `beat_last`: drop the line, increment `err_count`, go to IDLE.
  - k==7 with `beat_last`: push {line, address} into the FIFO, go to IDLE.
  - k==7 without `beat_last`: drop the line, increment `err_count`, go to DRAIN.
- DRAIN: accept beats and discard them. Go to IDLE on the accepted beat that carries `beat_last`.
- `beat_ready` is 1 except when:
  - state is FILL, count==7, the FIFO is full, and no pop occurs this cycle;
  - or reset is asserted.
- A push and a pop in the same cycle are both honoured when the FIFO is full.
- `err_count` saturates at 255 and never wraps.
- `line_valid` = FIFO not empty.
- `linha_cache`/`endereco` show the FIFO head. They hold stable while `line_valid && !line_ready`.

## Timing
- Reset (`reset`==0 at a clock edge):
  - state IDLE, count 0;
  - FIFO empty, `line_valid`=0;
  - `linha_cache`=0, `endereco`=0, `err_count`=0;
  - `beat_ready`=0 during reset, 1 on the first cycle after reset.
- Reset mid-burst discards the partial line without counting an error.
- Latency: `line_valid` rises on the cycle after the 8th beat is accepted (1 cycle). It is registered, with no combinational path from `beat_*` to `line_*`.
- Throughput: one beat per cycle sustained. Back-to-back bursts need no idle cycle between them.
- `beat_ready` may depend combinationally on `line_ready`, because of the pop bypass. `line_valid` must not depend combinationally on `beat_valid`.
- FIFO order is strict first-in first-out. Pointers wrap modulo `DEPTH`.

## Structure
- Shared package `hardcore_pkg` holds:
  - `LINE_W`, `WORDS_PER_LINE`=8, `LINE_OFFSET_BITS`=6;
  - the `asm_state_t` enum (IDLE, FILL, DRAIN).
- Sub-module `line_fifo`:
  - parameters `WIDTH`, `DEPTH`;
  - ports push/pop/full/empty/head;
  - holds {`endereco`, `linha_cache`} of `ADDR_W`+`LINE_W` bits.
- The top level contains the FSM, beat counter, line shift/write register, and error counter.

## Test plan
- Single burst: beats 0x0..0x7, `beat_addr`=0x1047, `line_ready`=1.
  - `line_valid` is high 1 cycle after beat 7.
  - `endereco`=0x1040.
  - `linha_cache` word k = k.
  - `err_count`=0.
- Back-pressure: `line_ready`=0 while 3 bursts are sent.
  - Two lines are buffered.
  - `beat_ready` drops at the 8th beat of burst 3.
  - Raising `line_ready` pops lines in order, and burst 3 completes.
- Short burst: `beat_last` on beat 3, followed by a good burst.
  - `err_count`=1.
  - Only the good line appears.
- Long burst: 10 beats with `beat_last` on beat 9, followed by a good burst.
  - DRAIN consumes beats 8–9.
  - `err_count`=1.
  - Only the good line appears.
- Full FIFO with a simultaneous push and pop: no beat is lost, no line is duplicated, and `beat_ready` stays 1.
- Reset asserted after 4 beats, then a full burst: no line from the partial burst appears, `err_count`=0, and the new line is correct.
